fir_pair_sequencer: RTL and testbench



---
 rtl/fir_seq_pkg.sv | 32 +++
 rtl/fir_seq_lfsr.sv | 46 ++++
 rtl/fir_pair_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_fir_pair_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// ============================================================================
// Module  : fir_seq_pkg
// Brief   : Shared types and constants for the FIR pair sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int FIR_SEQ_WIDTH = 24;
    localparam int LFSR_W        = 24;

    // Galois form of x^24 + x^23 + x^22 + x^17 + 1, right-shifting.
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK     = 24'hE10000;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 24'h5A5A5A;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAP_MASK) : (cur >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_seq_lfsr.sv
// ============================================================================
// Module  : fir_seq_lfsr
// Brief   : 24-bit Galois LFSR sample source with seed load and step enable.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_seq_lfsr
    import fir_seq_pkg::*;
#(
    parameter int                WIDTH = FIR_SEQ_WIDTH,
    parameter logic [LFSR_W-1:0] SEED  = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] value_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // A load takes priority so a fresh run always begins from the seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = WIDTH'(lfsr_q);

endmodule

`default_nettype wire

// File: rtl/fir_pair_sequencer.sv
// ============================================================================
// Module  : fir_pair_sequencer
// Brief   : Feeds one sample at a time to two FIR variants and counts output
//           mismatches. Define FIR_SEQ_LFSR_EN to source samples from an LFSR.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_pair_sequencer
    import fir_seq_pkg::*;
#(
    parameter int                WIDTH     = FIR_SEQ_WIDTH,
    parameter int                LATENCY   = 8,
    parameter int                CNT_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] fir_input_sig,
    output logic             fir_ready,
    input  logic [WIDTH-1:0] fir_sig_a,
    input  logic [WIDTH-1:0] fir_sig_b,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int                c_WAIT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(LATENCY - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    mis_q, mis_d;
    logic [CNT_W-1:0]    first_q, first_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    sample_q, sample_d;
    logic [c_WAIT_W-1:0] wait_q, wait_d;

    logic                w_fetch_ok;
    logic [WIDTH-1:0]    w_fetch_data;

`ifdef FIR_SEQ_LFSR_EN
    logic             w_lfsr_load;
    logic             w_lfsr_step;
    logic [WIDTH-1:0] w_lfsr_value;
    logic             w_unused_stream;

    assign w_lfsr_load     = (state_q == ST_IDLE) && start;
    assign w_lfsr_step     = (state_q == ST_FETCH) && !abort;
    assign w_unused_stream = ^{s_data, s_valid};

    fir_seq_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_lfsr_load),
        .step_i  (w_lfsr_step),
        .value_o (w_lfsr_value)
    );

    assign s_ready      = 1'b0;
    assign w_fetch_ok   = 1'b1;
    assign w_fetch_data = w_lfsr_value;
`else
    logic [LFSR_W-1:0] w_unused_seed;

    assign w_unused_seed = LFSR_SEED;
    // Deassert ready on abort so no sample is consumed by a run being torn down.
    assign s_ready       = (state_q == ST_FETCH) && !abort;
    assign w_fetch_ok    = s_valid;
    assign w_fetch_data  = s_data;
`endif

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        mis_d     = mis_q;
        first_d   = first_q;
        err_d     = err_q;
        sample_d  = sample_q;
        wait_d    = wait_q;
        fir_ready = 1'b0;
        done      = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_d   = num_samples;
                        idx_d   = '0;
                        mis_d   = '0;
                        first_d = '0;
                        err_d   = 1'b0;
                        state_d = (num_samples == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_ok) begin
                        sample_d = w_fetch_data;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    fir_ready = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = ST_CMP;
                    end else begin
                        wait_d  = c_WAIT_INIT;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_d = wait_q - c_WAIT_ONE;
                    if (wait_q == c_WAIT_ONE) begin
                        state_d = ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (fir_sig_a != fir_sig_b) begin
                        if (mis_q != '1) begin
                            mis_d = mis_q + c_CNT_ONE;
                        end
                        if (!err_q) begin
                            first_d = idx_q;
                        end
                        err_d = 1'b1;
                    end
                    if (idx_q == (num_q - c_CNT_ONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + c_CNT_ONE;
                        state_d = ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            num_q    <= '0;
            idx_q    <= '0;
            mis_q    <= '0;
            first_q  <= '0;
            err_q    <= 1'b0;
            sample_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            mis_q    <= mis_d;
            first_q  <= first_d;
            err_q    <= err_d;
            sample_q <= sample_d;
            wait_q   <= wait_d;
        end
    end

    assign fir_input_sig = sample_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_flag      = err_q;
    assign mismatch_cnt  = mis_q;
    assign first_err_idx = first_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_pair_sequencer.sv
// ============================================================================
// Module  : tb_fir_pair_sequencer
// Brief   : Directed self-checking bench for fir_pair_sequencer; the LFSR
//           sequence checks apply when FIR_SEQ_LFSR_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_pair_sequencer;

    localparam int WIDTH   = 24;
    localparam int LATENCY = 8;
    localparam int CNT_W   = 16;
    localparam int PERIOD  = LATENCY + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] fir_input_sig;
    logic             fir_ready;
    logic [WIDTH-1:0] fir_sig_a;
    logic [WIDTH-1:0] fir_sig_b;
    logic             busy;
    logic             done;
    logic             err_flag;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_err_idx;

    always #5 clk = ~clk;

    fir_pair_sequencer #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_samples   (num_samples),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .fir_input_sig (fir_input_sig),
        .fir_ready     (fir_ready),
        .fir_sig_a     (fir_sig_a),
        .fir_sig_b     (fir_sig_b),
        .busy          (busy),
        .done          (done),
        .err_flag      (err_flag),
        .mismatch_cnt  (mismatch_cnt),
        .first_err_idx (first_err_idx)
    );

    // Filter pair model: outputs agree only exactly LATENCY cycles after a strobe,
    // and b is corrupted on the sample indices selected by corrupt_mask.
    logic [WIDTH-1:0] held_q = '0;
    int               age_q = 1000;
    logic             corr_q = 1'b0;
    int               issue_cnt = 0;
    logic [15:0]      corrupt_mask = '0;

    always @(posedge clk) begin
        if (start && !busy) issue_cnt <= 0;
        if (fir_ready) begin
            held_q    <= fir_input_sig;
            age_q     <= 0;
            corr_q    <= corrupt_mask[issue_cnt[3:0]];
            issue_cnt <= issue_cnt + 1;
        end else if (age_q < 1000) begin
            age_q <= age_q + 1;
        end
    end

    assign fir_sig_a = held_q;
    assign fir_sig_b = (age_q == LATENCY - 1) ? (held_q ^ {{(WIDTH-1){1'b0}}, corr_q}) : ~held_q;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [WIDTH-1:0] samp [8];

    typedef struct {
        int          num;
        logic [15:0] mask;
        int          mis;
        logic        err;
        int          first;
    } vec_t;

    vec_t tab [6];

    task automatic start_run(input int num);
        @(negedge clk);
        start       = 1'b1;
        num_samples = CNT_W'(num);
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic run_stream(input vec_t v);
        int pulses, done_cyc, last_p, didx;
        bit fin, acc;
        corrupt_mask = v.mask;
        s_valid = 1'b1;
        didx = 0;
        s_data = samp[0];
        start_run(v.num);
        pulses = 0; done_cyc = -1; last_p = -1; fin = 0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            if (fir_ready) begin
                chk("sample_out", {40'b0, fir_input_sig}, {40'b0, samp[pulses % 8]});
                if (last_p >= 0) chk("strobe_spacing", c - last_p, PERIOD);
                last_p = c;
                pulses++;
            end
            if (done) begin
                fin = 1;
                done_cyc = c;
            end
            acc = s_ready && s_valid;
            @(negedge clk);
            if (acc) begin
                didx++;
                s_data = samp[didx % 8];
            end
        end
        chk("done_timing", done_cyc, PERIOD * v.num);
        chk("pulse_count", pulses, v.num);
        chk("mismatch_cnt", {48'b0, mismatch_cnt}, v.mis);
        chk("err_flag", {63'b0, err_flag}, {63'b0, v.err});
        chk("first_err_idx", {48'b0, first_err_idx}, v.first);
        chk("idle_after_done", {63'b0, busy}, 0);
        s_valid = 1'b0;
    endtask

`ifdef FIR_SEQ_LFSR_EN
    logic [WIDTH-1:0] lfsr_exp [3];

    task automatic run_lfsr(input int num);
        int pulses, rdy_seen;
        bit fin;
        start_run(num);
        pulses = 0; rdy_seen = 0; fin = 0;
        for (int c = 0; c < 500 && !fin; c++) begin
            if (s_ready) rdy_seen++;
            if (fir_ready) begin
                chk("lfsr_sample", {40'b0, fir_input_sig}, {40'b0, lfsr_exp[pulses % 3]});
                pulses++;
            end
            if (done) fin = 1;
            @(negedge clk);
        end
        chk("lfsr_done_seen", {63'b0, fin}, 1);
        chk("lfsr_pulse_count", pulses, num);
        chk("lfsr_s_ready_low", rdy_seen, 0);
    endtask
`endif

    initial begin
        int  bad, pulses, evts;
        bit  fin;

        samp[0] = 24'h000064; samp[1] = 24'hFFFF9C; samp[2] = 24'h000007; samp[3] = 24'h000000;
        samp[4] = 24'hFFFFFF; samp[5] = 24'h7FFFFF; samp[6] = 24'h800000; samp[7] = 24'h00002A;

        tab[0] = '{num: 4, mask: 16'h0000, mis: 0, err: 1'b0, first: 0};
        tab[1] = '{num: 4, mask: 16'h000A, mis: 2, err: 1'b1, first: 1};
        tab[2] = '{num: 0, mask: 16'h0000, mis: 0, err: 1'b0, first: 0};
        tab[3] = '{num: 6, mask: 16'h0031, mis: 3, err: 1'b1, first: 0};
        tab[4] = '{num: 1, mask: 16'h0001, mis: 1, err: 1'b1, first: 0};
        tab[5] = '{num: 5, mask: 16'h0010, mis: 1, err: 1'b1, first: 4};

        repeat (2) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 0);
        chk("rst_done", {63'b0, done}, 0);
        chk("rst_fir_ready", {63'b0, fir_ready}, 0);
        chk("rst_s_ready", {63'b0, s_ready}, 0);
        chk("rst_err_flag", {63'b0, err_flag}, 0);
        chk("rst_mismatch_cnt", {48'b0, mismatch_cnt}, 0);
        chk("rst_first_err_idx", {48'b0, first_err_idx}, 0);
        chk("rst_fir_input_sig", {40'b0, fir_input_sig}, 0);
        rst_n = 1'b1;

`ifdef FIR_SEQ_LFSR_EN
        lfsr_exp[0] = 24'h5A5A5A; lfsr_exp[1] = 24'h2D2D2D; lfsr_exp[2] = 24'hF79696;
        run_lfsr(3);
        run_lfsr(1);
`else
        for (int i = 0; i < 6; i++) run_stream(tab[i]);

        // Stall: s_valid withheld for 10 cycles while the sequencer sits in FETCH.
        corrupt_mask = 16'h0001;
        s_valid = 1'b1;
        s_data  = samp[2];
        start_run(3);
        pulses = 0; fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (fir_ready) begin
                pulses++;
                s_valid = 1'b0;
            end
            if (s_ready && !s_valid) fin = 1;
            else @(negedge clk);
        end
        chk("stall_reach_fetch", {63'b0, fin}, 1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!s_ready || fir_ready || !busy || mismatch_cnt != 16'd1) bad++;
            @(negedge clk);
        end
        chk("stall_hold", bad, 0);
        s_valid = 1'b1;
        fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (fir_ready) pulses++;
            if (done) fin = 1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("stall_done", {63'b0, fin}, 1);
        chk("stall_pulses", pulses, 3);
        chk("stall_mismatch_cnt", {48'b0, mismatch_cnt}, 1);

        // Abort during WAIT of sample index 2 in a 5-sample run.
        corrupt_mask = 16'h0005;
        s_valid = 1'b1;
        s_data  = samp[0];
        start_run(5);
        pulses = 0; fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (fir_ready) pulses++;
            @(negedge clk);
            if (pulses == 3) fin = 1;
        end
        chk("abort_reach_wait", {62'b0, fin, busy}, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_next", {63'b0, busy}, 0);
        evts = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || fir_ready || busy) evts++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("abort_quiet", evts, 0);
        chk("abort_mismatch_cnt", {48'b0, mismatch_cnt}, 1);
        chk("abort_err_flag", {63'b0, err_flag}, 1);
        chk("abort_first_err_idx", {48'b0, first_err_idx}, 0);

        // start and abort together in IDLE: the start is accepted.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_samples = 16'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_wins_busy", {63'b0, busy}, 1);
        chk("start_wins_stats_clear", {48'b0, mismatch_cnt}, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_from_fetch", {63'b0, busy}, 0);

        // Asynchronous reset mid-run.
        s_valid = 1'b1;
        start_run(2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", {63'b0, busy}, 0);
        chk("midrun_reset_fir_ready", {63'b0, fir_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {63'b0, busy}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
